// File: rtl/spi_arb.sv
// rtl/spi_arb.sv - round-robin arbiter sharing one SPI master between two requesters
module spi_arb #(
    parameter int TMO_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        wrt0,
    input  logic        wrt1,
    input  logic [15:0] wt_data0,
    input  logic [15:0] wt_data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rd_data,
    output logic        spi_wrt,
    output logic [15:0] spi_wt_data,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    input  logic        clr_err,
    output logic        err
);

    localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

    typedef enum logic [1:0] {IDLE, OWN, XFER} state_t;

    state_t          state, state_nxt;
    logic            owner, owner_nxt;
    logic            last, last_nxt;
    logic [CW-1:0]   cnt;
    logic            err_r;
    logic            own_req, own_wrt, tmo;

    assign own_req = owner ? req1 : req0;
    assign own_wrt = owner ? wrt1 : wrt0;
    assign tmo     = (state == XFER) && !spi_done && (cnt == CW'(TMO_CYC - 1));

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    owner_nxt = ~last;
                    state_nxt = OWN;
                end else if (req0 || req1) begin
                    owner_nxt = req1;
                    state_nxt = OWN;
                end
            end
            OWN: begin
                // A start in the same cycle as req falling still launches the transfer
                if (own_wrt) begin
                    state_nxt = XFER;
                end else if (!own_req) begin
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end
            XFER: begin
                if (spi_done) begin
                    state_nxt = OWN;
                end else if (tmo) begin
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= (state == XFER && state_nxt == XFER) ? cnt + 1'b1 : '0;
            if (tmo)
                err_r <= 1'b1;
            else if (clr_err)
                err_r <= 1'b0;
        end
    end

    assign gnt0        = (state != IDLE) && !owner;
    assign gnt1        = (state != IDLE) && owner;
    assign done0       = (state == XFER) && spi_done && !owner;
    assign done1       = (state == XFER) && spi_done && owner;
    assign spi_wrt     = (state == OWN) && own_wrt;
    assign spi_wt_data = (state == IDLE) ? 16'h0000 : (owner ? wt_data1 : wt_data0);
    assign rd_data     = spi_rd_data;
    assign err         = err_r;

endmodule

// File: tb/tb_spi_arb.sv
// tb/tb_spi_arb.sv - directed vector bench for spi_arb
module tb_spi_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, wrt0, wrt1;
    logic [15:0] wt_data0, wt_data1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] rd_data;
    logic        spi_wrt;
    logic [15:0] spi_wt_data;
    logic        spi_done;
    logic [15:0] spi_rd_data;
    logic        clr_err;
    logic        err;

    int passed = 0;
    int total  = 0;

    spi_arb #(.TMO_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wrt0(wrt0), .wrt1(wrt1),
        .wt_data0(wt_data0), .wt_data1(wt_data1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rd_data(rd_data), .spi_wrt(spi_wrt), .spi_wt_data(spi_wt_data),
        .spi_done(spi_done), .spi_rd_data(spi_rd_data),
        .clr_err(clr_err), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [15:0] d0, d1;
        logic        sd;
        logic [15:0] srd;
        logic        clr;
        logic        g0, g1, dn0, dn1, sw;
        logic [15:0] swd;
        logic        e;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic r0, logic r1, logic w0, logic w1,
                                logic [15:0] d0, logic [15:0] d1, logic sd,
                                logic [15:0] srd, logic clr,
                                logic g0, logic g1, logic dn0, logic dn1,
                                logic sw, logic [15:0] swd, logic e);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1; v.d0 = d0; v.d1 = d1;
        v.sd = sd; v.srd = srd; v.clr = clr;
        v.g0 = g0; v.g1 = g1; v.dn0 = dn0; v.dn1 = dn1; v.sw = sw; v.swd = swd; v.e = e;
        return v;
    endfunction

    task automatic check(string name, logic [15:0] got, logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic drive_idle();
        req0 = 0; req1 = 0; wrt0 = 0; wrt1 = 0;
        wt_data0 = 16'h0; wt_data1 = 16'h0;
        spi_done = 0; spi_rd_data = 16'h0; clr_err = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        step();
        step();
        rst = 1'b0;

        //            r0 r1 w0 w1 d0        d1        sd srd       clr  g0 g1 dn0 dn1 sw swd       e
        vecs[0]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 16'h0000, 0);
        vecs[1]  = mk(1, 1, 0, 0, 16'h2000, 16'h1234, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 16'h0000, 0);
        vecs[2]  = mk(1, 1, 0, 1, 16'h2000, 16'h1234, 0, 16'h0000, 0,   1, 0, 0, 0, 0, 16'h2000, 0);
        vecs[3]  = mk(1, 1, 0, 0, 16'h2000, 16'h1234, 1, 16'h5555, 0,   1, 0, 0, 0, 0, 16'h2000, 0);
        vecs[4]  = mk(1, 1, 1, 0, 16'h2000, 16'h1234, 0, 16'h0000, 0,   1, 0, 0, 0, 1, 16'h2000, 0);
        vecs[5]  = mk(1, 1, 1, 0, 16'h2000, 16'h1234, 0, 16'h0000, 0,   1, 0, 0, 0, 0, 16'h2000, 0);
        vecs[6]  = mk(1, 1, 0, 0, 16'h2000, 16'h1234, 1, 16'h0ABC, 0,   1, 0, 1, 0, 0, 16'h2000, 0);
        vecs[7]  = mk(1, 1, 1, 0, 16'h3001, 16'h1234, 0, 16'h0000, 0,   1, 0, 0, 0, 1, 16'h3001, 0);
        vecs[8]  = mk(1, 1, 0, 0, 16'h3001, 16'h1234, 1, 16'h0DEF, 0,   1, 0, 1, 0, 0, 16'h3001, 0);
        vecs[9]  = mk(0, 1, 0, 0, 16'h3001, 16'h4444, 0, 16'h0000, 0,   1, 0, 0, 0, 0, 16'h3001, 0);
        vecs[10] = mk(0, 1, 0, 0, 16'h0000, 16'h4444, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 16'h0000, 0);
        vecs[11] = mk(0, 1, 0, 0, 16'h0000, 16'h4444, 0, 16'h0000, 0,   0, 1, 0, 0, 0, 16'h4444, 0);
        vecs[12] = mk(0, 1, 0, 1, 16'h0000, 16'h4444, 0, 16'h0000, 0,   0, 1, 0, 0, 1, 16'h4444, 0);
        vecs[13] = mk(0, 0, 1, 0, 16'h0000, 16'h4444, 0, 16'h0000, 0,   0, 1, 0, 0, 0, 16'h4444, 0);
        vecs[14] = mk(0, 0, 0, 0, 16'h0000, 16'h4444, 1, 16'h1357, 0,   0, 1, 0, 1, 0, 16'h4444, 0);
        vecs[15] = mk(0, 0, 0, 0, 16'h0000, 16'h4444, 0, 16'h0000, 0,   0, 1, 0, 0, 0, 16'h4444, 0);
        vecs[16] = mk(1, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 16'h0000, 0);
        vecs[17] = mk(0, 0, 0, 0, 16'h00AA, 16'h0000, 0, 16'h0000, 0,   1, 0, 0, 0, 0, 16'h00AA, 0);
        vecs[18] = mk(1, 1, 0, 0, 16'h00AA, 16'h00BB, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 16'h0000, 0);
        vecs[19] = mk(1, 1, 0, 0, 16'h00AA, 16'h00BB, 0, 16'h0000, 0,   0, 1, 0, 0, 0, 16'h00BB, 0);
        vecs[20] = mk(0, 0, 0, 0, 16'h00AA, 16'h00BB, 0, 16'h0000, 0,   0, 1, 0, 0, 0, 16'h00BB, 0);
        vecs[21] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 16'h0000, 0);

        for (int i = 0; i < 22; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; wrt0 = vecs[i].w0; wrt1 = vecs[i].w1;
            wt_data0 = vecs[i].d0; wt_data1 = vecs[i].d1;
            spi_done = vecs[i].sd; spi_rd_data = vecs[i].srd; clr_err = vecs[i].clr;
            @(negedge clk);
            check($sformatf("v%0d gnt0", i), {15'h0, gnt0}, {15'h0, vecs[i].g0});
            check($sformatf("v%0d gnt1", i), {15'h0, gnt1}, {15'h0, vecs[i].g1});
            check($sformatf("v%0d done0", i), {15'h0, done0}, {15'h0, vecs[i].dn0});
            check($sformatf("v%0d done1", i), {15'h0, done1}, {15'h0, vecs[i].dn1});
            check($sformatf("v%0d spi_wrt", i), {15'h0, spi_wrt}, {15'h0, vecs[i].sw});
            check($sformatf("v%0d spi_wt_data", i), spi_wt_data, vecs[i].swd);
            check($sformatf("v%0d err", i), {15'h0, err}, {15'h0, vecs[i].e});
            check($sformatf("v%0d rd_data", i), rd_data, vecs[i].srd);
            step();
        end

        // Timeout: 16 edges after entering XFER the grant drops and err sets
        drive_idle();
        req0 = 1;
        step();
        wrt0 = 1; wt_data0 = 16'hA5A5;
        @(negedge clk);
        check("tmo spi_wrt", {15'h0, spi_wrt}, 16'h1);
        step();
        wrt0 = 0;
        for (int k = 1; k < 16; k++) step();
        check("tmo gnt0 at 15", {15'h0, gnt0}, 16'h1);
        check("tmo err at 15", {15'h0, err}, 16'h0);
        step();
        check("tmo gnt0 at 16", {15'h0, gnt0}, 16'h0);
        check("tmo err at 16", {15'h0, err}, 16'h1);
        check("tmo no done0", {15'h0, done0}, 16'h0);
        req0 = 0; clr_err = 1;
        step();
        check("clr_err clears", {15'h0, err}, 16'h0);
        clr_err = 0;
        step();

        // Timeout coinciding with clr_err keeps err set
        req0 = 1;
        step();
        wrt0 = 1;
        step();
        wrt0 = 0;
        for (int k = 1; k < 16; k++) step();
        check("tmo2 err before", {15'h0, err}, 16'h0);
        clr_err = 1;
        step();
        check("tmo beats clr_err", {15'h0, err}, 16'h1);
        check("tmo2 gnt0", {15'h0, gnt0}, 16'h0);
        clr_err = 0; req0 = 0;
        step();

        // Reset mid-transfer, then a late spi_done
        req0 = 1;
        step();
        wrt0 = 1;
        step();
        wrt0 = 0;
        step();
        check("pre-rst gnt0", {15'h0, gnt0}, 16'h1);
        rst = 1;
        step();
        rst = 0; req0 = 0; spi_done = 1; spi_rd_data = 16'h7777;
        @(negedge clk);
        check("rst gnt0", {15'h0, gnt0}, 16'h0);
        check("rst done0", {15'h0, done0}, 16'h0);
        check("rst spi_wrt", {15'h0, spi_wrt}, 16'h0);
        check("rst err", {15'h0, err}, 16'h0);
        check("rst spi_wt_data", spi_wt_data, 16'h0000);
        step();
        spi_done = 0;
        @(negedge clk);
        check("post-rst gnt0", {15'h0, gnt0}, 16'h0);
        check("post-rst gnt1", {15'h0, gnt1}, 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
